// File: rtl/phase_cmd_pkg.sv
// phase_cmd_pkg
//   Shared definitions for the phase command scheduler: command opcodes,
//   FSM state encoding, status/error reply field positions and a helper
//   that packs the status reply word.
package phase_cmd_pkg;

  // Command opcodes, carried in bits [23:20] of a host command word.
  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_SET_ADDR   = 4'h1;
  localparam logic [3:0] OP_WRITE      = 4'h2;
  localparam logic [3:0] OP_COMMIT     = 4'h3;
  localparam logic [3:0] OP_SET_ENABLE = 4'h4;
  localparam logic [3:0] OP_STATUS     = 4'h5;

  // Reply tags, placed in bits [23:20] of a reply word.
  localparam logic [3:0] STATUS_TAG    = 4'h5;
  localparam logic [3:0] ERR_TAG       = 4'hE;

  // Status reply field positions.
  localparam int STS_EN_BIT     = 19;
  localparam int STS_PEND_BIT   = 18;
  localparam int STS_DROP_BIT   = 17;
  localparam int STS_OVF_BIT    = 16;
  localparam int STS_ERR_LSB    = 8;
  localparam int STS_PTR_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_EXEC       = 2'd1,
    ST_WAIT_FRAME = 2'd2,
    ST_REPLY      = 2'd3
  } state_e;

  // Packs the status reply word from its individual fields.
  function automatic logic [23:0] pack_status(input logic       en,
                                              input logic       pend,
                                              input logic       drop,
                                              input logic       ovf,
                                              input logic [7:0] err,
                                              input logic [7:0] ptr8);
    logic [23:0] w;
    w                             = 24'h000000;
    w[23:20]                      = STATUS_TAG;
    w[STS_EN_BIT]                 = en;
    w[STS_PEND_BIT]               = pend;
    w[STS_DROP_BIT]               = drop;
    w[STS_OVF_BIT]                = ovf;
    w[STS_ERR_LSB+7:STS_ERR_LSB]  = err;
    w[STS_PTR_LSB+7:STS_PTR_LSB]  = ptr8;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo
//   Synchronous FIFO holding host command words. The head entry is
//   presented combinationally on dout_o. A push while full is accepted
//   only when a pop happens in the same cycle; otherwise it is ignored
//   (the caller decides what a dropped push means).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i, din_i  write strobe and data
//   pop_i          remove head entry (ignored when empty)
//   full_o         DEPTH entries stored
//   empty_o        no entries stored
//   dout_o         head entry
module cmd_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o   = (count_q == (PTR_W+1)'(0));
  assign dout_o    = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  // When full, the pop in the same cycle frees the slot being written.
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Next-state for pointers and occupancy count.
  always_comb begin
    rd_ptr_d = do_pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = do_push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= PTR_W'(0);
      wr_ptr_q <= PTR_W'(0);
      count_q  <= (PTR_W+1)'(0);
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/phase_cmd_scheduler.sv
// phase_cmd_scheduler
//   Buffers 24-bit host commands and decodes them into shadow phase-table
//   writes, output-enable control, frame-synchronous bank commit requests
//   and status/error replies. All outputs are registered and reset to 0.
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_command, i_command_data     command strobe and word ([23:20] opcode)
//   i_overflow                    decoder overflow, latched into a sticky
//   i_frame_start                 frame boundary pulse from the generator
//   o_reply, o_reply_data         reply strobe and word
//   o_wr_en, o_wr_addr, o_wr_data shadow phase-table write port
//   o_commit_req                  bank swap request (level)
//   o_enable                      channel output enable
module phase_cmd_scheduler
  import phase_cmd_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int PHASE_W    = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_command,
  input  logic [23:0]        i_command_data,
  input  logic               i_overflow,
  input  logic               i_frame_start,
  output logic               o_reply,
  output logic [23:0]        o_reply_data,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [PHASE_W-1:0] o_wr_data,
  output logic               o_commit_req,
  output logic               o_enable
);

  state_e             state_q, state_d;
  logic [23:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               enable_q, enable_d;
  logic               drop_q, drop_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         err_q, err_d;
  logic [23:0]        reply_word_q, reply_word_d;
  logic               reply_q, reply_d;
  logic [23:0]        reply_data_q, reply_data_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PHASE_W-1:0] wr_data_q, wr_data_d;
  logic               commit_q, commit_d;

  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_pop_s;
  logic [23:0]        fifo_head_s;
  logic               drop_set_s;
  logic               sticky_clr_s;
  logic [3:0]         opcode_s;
  logic [7:0]         ptr8_s;
  logic               unused_payload_s;

  cmd_fifo #(
    .WIDTH (24),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (i_command),
    .din_i   (i_command_data),
    .pop_i   (fifo_pop_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .dout_o  (fifo_head_s)
  );

  assign fifo_pop_s       = (state_q == ST_IDLE) && !fifo_empty_s;
  // A push into a full FIFO survives only if the head leaves this cycle.
  assign drop_set_s       = i_command && fifo_full_s && !fifo_pop_s;
  assign opcode_s         = cmd_q[23:20];
  assign unused_payload_s = ^cmd_q[19:0];

  // The status reply always carries exactly 8 pointer bits.
  if (ADDR_W >= 8) begin : g_ptr_trunc
    assign ptr8_s = ptr_q[7:0];
  end else begin : g_ptr_ext
    assign ptr8_s = {{(8-ADDR_W){1'b0}}, ptr_q};
  end

  // Command FSM next-state and datapath next values.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    ptr_d        = ptr_q;
    enable_d     = enable_q;
    err_d        = err_q;
    reply_word_d = reply_word_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    sticky_clr_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          cmd_d   = fifo_head_s;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (opcode_s)
          OP_NOP: begin
            state_d = ST_IDLE;
          end
          OP_SET_ADDR: begin
            ptr_d = cmd_q[ADDR_W-1:0];
          end
          OP_WRITE: begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = cmd_q[PHASE_W-1:0];
            ptr_d     = ptr_q + ADDR_W'(1);
          end
          OP_COMMIT: begin
            state_d = ST_WAIT_FRAME;
          end
          OP_SET_ENABLE: begin
            enable_d = cmd_q[0];
          end
          OP_STATUS: begin
            // Snapshot before the stickies clear; a same-cycle set
            // still lands in the sticky for the next read.
            reply_word_d = pack_status(enable_q, commit_q, drop_q, ovf_q,
                                       err_q, ptr8_s);
            sticky_clr_s = 1'b1;
            state_d      = ST_REPLY;
          end
          default: begin
            err_d        = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            reply_word_d = {ERR_TAG, opcode_s, 16'h0000};
            state_d      = ST_REPLY;
          end
        endcase
      end
      ST_WAIT_FRAME: begin
        if (i_frame_start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_FRAME;
        end
      end
      ST_REPLY: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Set has priority over the STATUS clear.
    drop_d       = drop_set_s | (drop_q & ~sticky_clr_s);
    ovf_d        = i_overflow | (ovf_q & ~sticky_clr_s);
    commit_d     = (state_d == ST_WAIT_FRAME);
    reply_d      = (state_q == ST_REPLY);
    reply_data_d = (state_q == ST_REPLY) ? reply_word_q : reply_data_q;
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= 24'h000000;
      ptr_q        <= ADDR_W'(0);
      enable_q     <= 1'b0;
      drop_q       <= 1'b0;
      ovf_q        <= 1'b0;
      err_q        <= 8'h00;
      reply_word_q <= 24'h000000;
      reply_q      <= 1'b0;
      reply_data_q <= 24'h000000;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= ADDR_W'(0);
      wr_data_q    <= PHASE_W'(0);
      commit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      ptr_q        <= ptr_d;
      enable_q     <= enable_d;
      drop_q       <= drop_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      reply_word_q <= reply_word_d;
      reply_q      <= reply_d;
      reply_data_q <= reply_data_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      commit_q     <= commit_d;
    end
  end

  assign o_reply      = reply_q;
  assign o_reply_data = reply_data_q;
  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_commit_req = commit_q;
  assign o_enable     = enable_q;

endmodule

// File: tb/tb_phase_cmd_scheduler.sv
// tb_phase_cmd_scheduler
//   Directed bench with scoreboard queues for writes and replies; a
//   negedge monitor pops and compares whenever the DUT strobes an output.
module tb_phase_cmd_scheduler;

  logic        i_clk;
  logic        i_rst;
  logic        i_command;
  logic [23:0] i_command_data;
  logic        i_overflow;
  logic        i_frame_start;
  logic        o_reply;
  logic [23:0] o_reply_data;
  logic        o_wr_en;
  logic [7:0]  o_wr_addr;
  logic [7:0]  o_wr_data;
  logic        o_commit_req;
  logic        o_enable;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_wr_q [$];
  logic [23:0] exp_rp_q [$];

  phase_cmd_scheduler #(
    .ADDR_W     (8),
    .PHASE_W    (8),
    .FIFO_DEPTH (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_command      (i_command),
    .i_command_data (i_command_data),
    .i_overflow     (i_overflow),
    .i_frame_start  (i_frame_start),
    .o_reply        (o_reply),
    .o_reply_data   (o_reply_data),
    .o_wr_en        (o_wr_en),
    .o_wr_addr      (o_wr_addr),
    .o_wr_data      (o_wr_data),
    .o_commit_req   (o_commit_req),
    .o_enable       (o_enable)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Monitor: compare every write/reply strobe against the scoreboard.
  always @(negedge i_clk) begin
    if (o_wr_en) begin
      if (exp_wr_q.size() == 0) unexpected("write", {16'h0, o_wr_addr, o_wr_data});
      else chk("write", {16'h0, o_wr_addr, o_wr_data}, {16'h0, exp_wr_q.pop_front()});
    end
    if (o_reply) begin
      if (exp_rp_q.size() == 0) unexpected("reply", {8'h0, o_reply_data});
      else chk("reply", {8'h0, o_reply_data}, {8'h0, exp_rp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Strobe one command; returns one cycle after it was sampled.
  task automatic send(input logic [23:0] cmd);
    i_command      = 1'b1;
    i_command_data = cmd;
    tick();
    i_command      = 1'b0;
    i_command_data = 24'h000000;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_reply"},      {31'h0, o_reply},      32'h0);
    chk({tag, "_reply_data"}, {8'h0, o_reply_data},  32'h0);
    chk({tag, "_wr_en"},      {31'h0, o_wr_en},      32'h0);
    chk({tag, "_wr_addr"},    {24'h0, o_wr_addr},    32'h0);
    chk({tag, "_wr_data"},    {24'h0, o_wr_data},    32'h0);
    chk({tag, "_commit_req"}, {31'h0, o_commit_req}, 32'h0);
    chk({tag, "_enable"},     {31'h0, o_enable},     32'h0);
  endtask

  initial begin
    i_rst          = 1'b1;
    i_command      = 1'b0;
    i_command_data = 24'h000000;
    i_overflow     = 1'b0;
    i_frame_start  = 1'b0;
    ticks(3);
    chk_outputs_zero("reset");
    i_rst = 1'b0;
    tick();

    // Pointer wrap across writes, then STATUS latency and pointer field.
    exp_wr_q.push_back({8'hFE, 8'h11});
    exp_wr_q.push_back({8'hFF, 8'h22});
    exp_wr_q.push_back({8'h00, 8'h33});
    send(24'h1000FE);
    send(24'h200011);
    send(24'h200022);
    send(24'h200033);
    ticks(12);
    exp_rp_q.push_back(24'h500001);
    send(24'h500000);
    ticks(2);
    chk("status_lat_c3", {31'h0, o_reply}, 32'h0);
    tick();
    chk("status_lat_c4", {31'h0, o_reply}, 32'h1);
    ticks(5);

    // COMMIT; a frame pulse during its EXEC is ignored; queued WRITE waits.
    send(24'h300000);
    chk("commit_c1", {31'h0, o_commit_req}, 32'h0);
    tick();
    chk("commit_c2", {31'h0, o_commit_req}, 32'h0);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("commit_c3", {31'h0, o_commit_req}, 32'h1);
    send(24'h200044);
    for (int k = 0; k < 18; k++) begin
      tick();
      chk("commit_hold", {31'h0, o_commit_req}, 32'h1);
    end
    i_frame_start = 1'b1;
    chk("commit_before_frame", {31'h0, o_commit_req}, 32'h1);
    tick();
    i_frame_start = 1'b0;
    chk("commit_after_frame", {31'h0, o_commit_req}, 32'h0);
    exp_wr_q.push_back({8'h01, 8'h44});
    ticks(8);

    // Ten strobes while stalled: eight accepted, two dropped.
    send(24'h300000);
    ticks(2);
    for (int k = 0; k < 10; k++) send(24'h200060 + 24'(k));
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    for (int k = 0; k < 8; k++) exp_wr_q.push_back({8'(8'h02 + k), 8'(8'h60 + k)});
    ticks(25);
    exp_rp_q.push_back(24'h52000A);
    exp_rp_q.push_back(24'h50000A);
    send(24'h500000);
    send(24'h500000);
    ticks(10);

    // Unknown opcode: error replies and saturating error count.
    for (int k = 0; k < 300; k++) begin
      exp_rp_q.push_back(24'hE90000);
      send(24'h900000);
      ticks(2);
    end
    ticks(10);
    exp_rp_q.push_back(24'h50FF0A);
    send(24'h500000);
    ticks(10);

    // Enable latency, overflow sticky, set-beats-clear.
    send(24'h400001);
    tick();
    chk("enable_c2", {31'h0, o_enable}, 32'h0);
    tick();
    chk("enable_c3", {31'h0, o_enable}, 32'h1);
    ticks(5);
    i_overflow = 1'b1;
    tick();
    i_overflow = 1'b0;
    tick();
    exp_rp_q.push_back(24'h59FF0A);
    send(24'h500000);
    ticks(10);
    exp_rp_q.push_back(24'h58FF0A);
    send(24'h500000);
    tick();
    i_overflow = 1'b1;
    tick();
    i_overflow = 1'b0;
    ticks(10);
    exp_rp_q.push_back(24'h59FF0A);
    send(24'h500000);
    ticks(10);

    // Reset while waiting for a frame with three commands queued.
    send(24'h300000);
    ticks(2);
    send(24'h200070);
    send(24'h200071);
    send(24'h200072);
    chk("pre_rst_commit", {31'h0, o_commit_req}, 32'h1);
    i_rst = 1'b1;
    tick();
    chk_outputs_zero("mid_rst");
    tick();
    i_rst = 1'b0;
    ticks(20);
    exp_rp_q.push_back(24'h500000);
    send(24'h500000);
    ticks(10);

    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
    chk("rp_queue_drained", 32'(exp_rp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
